// File: rtl/riscii_dev_pkg.sv
// Shared definitions for the RISCII development chassis.
// Holds bus widths and the SRAM bridge state encoding.
package riscii_dev_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int WORD_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SETUP,
        WRITE,
        HOLD
    } sram_state_t;

endpackage

// File: rtl/sram_bridge.sv
// Bridge from the RISCII word memory port to the asynchronous 256Kx16 SRAM.
// One request at a time; strobes are registered from the next-state decode.
module sram_bridge
    import riscii_dev_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_reqValid,
    input  logic                   i_reqWrite,
    input  logic [WORD_W-1:0]      i_reqAddr,
    input  logic [WORD_W-1:0]      i_reqData,
    output logic                   o_reqReady,
    output logic                   o_rspValid,
    output logic [WORD_W-1:0]      o_rspData,
    output logic [SRAM_ADDR_W-1:0] o_sramAddr,
    output logic [WORD_W-1:0]      o_sramDataOut,
    output logic                   o_sramDataOE,
    input  logic [WORD_W-1:0]      i_sramDataIn,
    output logic                   o_sramCEn,
    output logic                   o_sramOEn,
    output logic                   o_sramWEn,
    output logic                   o_sramUBn,
    output logic                   o_sramLBn
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    sram_state_t state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept;
    logic        read_done;
    logic        ce_n_next, oe_n_next, we_n_next, bytes_n_next, data_oe_next;

    assign o_reqReady = (state == IDLE);
    assign accept     = i_reqValid && (state == IDLE);
    assign read_done  = (state == READ) && (cnt == 4'd0);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (i_reqValid) begin
                    cnt_next   = CNT_LOAD;
                    state_next = i_reqWrite ? SETUP : READ;
                end
            end
            READ: begin
                if (cnt == 4'd0) state_next = IDLE;
                else             cnt_next   = cnt - 4'd1;
            end
            SETUP: state_next = WRITE;
            WRITE: begin
                if (cnt == 4'd0) state_next = HOLD;
                else             cnt_next   = cnt - 4'd1;
            end
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobe levels are decoded from the state we are about to enter so
    // that the registered pins line up exactly with the state register.
    always_comb begin
        ce_n_next    = 1'b1;
        oe_n_next    = 1'b1;
        we_n_next    = 1'b1;
        bytes_n_next = 1'b1;
        data_oe_next = 1'b0;
        unique case (state_next)
            READ: begin
                ce_n_next    = 1'b0;
                oe_n_next    = 1'b0;
                bytes_n_next = 1'b0;
            end
            SETUP, HOLD: begin
                ce_n_next    = 1'b0;
                bytes_n_next = 1'b0;
                data_oe_next = 1'b1;
            end
            WRITE: begin
                ce_n_next    = 1'b0;
                we_n_next    = 1'b0;
                bytes_n_next = 1'b0;
                data_oe_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            o_rspValid    <= 1'b0;
            o_rspData     <= '0;
            o_sramAddr    <= '0;
            o_sramDataOut <= '0;
            o_sramDataOE  <= 1'b0;
            o_sramCEn     <= 1'b1;
            o_sramOEn     <= 1'b1;
            o_sramWEn     <= 1'b1;
            o_sramUBn     <= 1'b1;
            o_sramLBn     <= 1'b1;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            o_rspValid    <= read_done;
            o_sramDataOE  <= data_oe_next;
            o_sramCEn     <= ce_n_next;
            o_sramOEn     <= oe_n_next;
            o_sramWEn     <= we_n_next;
            o_sramUBn     <= bytes_n_next;
            o_sramLBn     <= bytes_n_next;
            if (read_done) o_rspData <= i_sramDataIn;
            if (accept) begin
                o_sramAddr    <= {2'b00, i_reqAddr};
                o_sramDataOut <= i_reqData;
            end
        end
    end

endmodule

// File: doc/sram_bridge.md
# sram_bridge

Sequential bridge between the RISCII microprocessor's 16-bit word memory port and the development board's asynchronous 256K×16 SRAM chip. Accepts one read or write request at a time over a valid/ready handshake, sequences the SRAM chip-enable, output-enable and write-enable strobes with a programmable access window, and returns read data through a one-cycle response pulse. Sits in the development chassis directly downstream of the DUT's memory interface and upstream of the SRAM pins. The top level builds the `SRAM_DQ` tristate from `o_sramDataOut` and `o_sramDataOE`.

## Interface
- `ACCESS_CYCLES`, default 2: number of clock cycles the read or write strobe is held active; legal range 1..15.
- `i_clk` in 1: single clock; all state changes on the rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_reqValid` in 1: request present.
- `i_reqWrite` in 1: 1 = write, 0 = read; qualified by `i_reqValid`.
- `i_reqAddr` in 16: word address.
- `i_reqData` in 16: write data.
- `o_reqReady` out 1: bridge can accept a request.
- `o_rspValid` out 1: one-cycle pulse, read data valid.
- `o_rspData` out 16: read data; holds its value until the next read completes.
- `o_sramAddr` out 18: SRAM address, equal to {2'b00, captured address}.
- `o_sramDataOut` out 16: write data toward the pad.
- `o_sramDataOE` out 1: 1 = drive `SRAM_DQ`.
- `i_sramDataIn` in 16: value on `SRAM_DQ`.
- `o_sramCEn`, `o_sramOEn`, `o_sramWEn`, `o_sramUBn`, `o_sramLBn` out 1 each: active-low SRAM strobes.

## Operation
- States: IDLE, READ, SETUP, WRITE, HOLD.
- A 4-bit wait counter counts within READ and WRITE.
- All SRAM-side outputs are registered, so the strobes are glitch-free.
- `o_reqReady` is 1 if and only if the state is IDLE.
- Acceptance:
  - A request is accepted on an edge where `i_reqValid` and `o_reqReady` are both 1.
  - On acceptance, the address and data are captured, so upstream may change its inputs afterwards.
  - On acceptance, the counter loads ACCESS_CYCLES-1.
- IDLE:
  - Outputs: CEn=OEn=WEn=UBn=LBn=1, DataOE=0.
  - Accepted read goes to READ; accepted write goes to SETUP.
- READ:
  - Outputs: CEn=OEn=UBn=LBn=0, WEn=1, DataOE=0.
  - The counter decrements each cycle.
  - On the edge where the counter is 0: capture `i_sramDataIn` into `o_rspData`, set `o_rspValid`=1 for exactly one cycle, and go to IDLE.
- SETUP (1 cycle):
  - Outputs: CEn=UBn=LBn=0, OEn=WEn=1, DataOE=1.
  - Goes to WRITE.
- WRITE:
  - Outputs: as SETUP, but WEn=0.
  - The counter decrements each cycle; on the edge where the counter is 0, go to HOLD.
- HOLD (1 cycle):
  - Outputs: WEn=1; CEn, DataOE, address and data unchanged.
  - Goes to IDLE.
- Writes never produce `o_rspValid`.
- Bus-contention invariants:
  - `o_sramOEn`=0 and `o_sramDataOE`=1 never occur together.
  - At least one cycle always separates OEn rising and DataOE rising; this is guaranteed by the mandatory IDLE cycle after READ.
  - WEn=0 only occurs while DataOE=1.
- `o_sramAddr` and `o_sramDataOut` hold their last values in IDLE.
- Reset:
  - Values: state IDLE, counter 0, `o_reqReady`=1, `o_rspValid`=0, `o_rspData`=0, `o_sramAddr`=0, `o_sramDataOut`=0, DataOE=0, all strobes=1.
  - Reset mid-operation aborts immediately and asynchronously.
  - An aborted read produces no response; an aborted write may leave that SRAM word undefined.
  - A request presented while `i_reset`=1 is not accepted.

## Timing
- Let N = ACCESS_CYCLES, with acceptance at edge E0.
- Read:
  - READ occupies cycles 1..N.
  - Data is sampled at edge EN.
  - `o_rspValid`=1 and `o_reqReady`=1 in cycle N+1.
  - Read-to-read throughput is one request per N+1 cycles; a new request may be accepted at edge EN+1, the same cycle the response is presented.
- Write:
  - SETUP occupies cycle 1.
  - WEn is low for cycles 2..N+1.
  - HOLD occupies cycle N+2.
  - `o_reqReady` returns in cycle N+3.
  - Write throughput is one request per N+3 cycles.
- Data hold and address stability:
  - Address and write data are stable for at least one full cycle before WEn falls and after it rises.
  - The address is stable for the entire CEn-low window.
- At 8.333 MHz with N=1, the 120 ns strobe width exceeds the SRAM's 10 ns access time.

## Structure
- Shared package `riscii_dev_pkg` contains:
  - `SRAM_ADDR_W`=18, `WORD_W`=16.
  - Typedef `sram_state_t`, an enum with values IDLE, READ, SETUP, WRITE, HOLD.
- No sub-module; the wait counter and FSM live in one module.
- The tristate stays in the chassis top level.

## Test plan
- Reset with `i_reset`=1 held 3 cycles: all strobes 1, DataOE=0, `o_reqReady`=1, `o_rspData`=16'h0000, `o_rspValid`=0 throughout.
- N=2, write 16'hBEEF to 16'h1234: SETUP 1 cycle, WEn low exactly 2 cycles, `o_sramAddr`=18'h01234, `o_sramDataOut`=16'hBEEF; ready returns in cycle 5; no `o_rspValid`.
- N=2, SRAM model holds 16'hBEEF at 18'h01234; read 16'h1234: OEn low 2 cycles, `o_rspValid`=1 in cycle 3 with `o_rspData`=16'hBEEF.
- N=1, back-to-back reads of 16'h0000 then 16'hFFFF with `i_reqValid` held high: second request accepted in the response cycle of the first; read period 2 cycles; address 18'h0FFFF on the second.
- Read immediately followed by write: OEn rises at least 1 cycle before DataOE rises; OEn=0 and DataOE=1 never occur together; write completes normally.
- `i_reset` asserted during a write's second WEn-low cycle: WEn, CEn and DataOE release without waiting for a clock edge; IDLE and ready=1 after release; a following read of another address returns correct data.
